// File: rtl/atm_pkg.sv
// Shared ATM definitions: one-hot note encoding, rupee values, FSM states, error codes.
// Bit positions of the note encoding match the switch-to-price decoder.
package atm_pkg;

  localparam logic [5:0] NOTE_NONE = 6'b000000;
  localparam logic [5:0] NOTE_5    = 6'b000010;
  localparam logic [5:0] NOTE_10   = 6'b000100;
  localparam logic [5:0] NOTE_20   = 6'b001000;
  localparam logic [5:0] NOTE_50   = 6'b010000;
  localparam logic [5:0] NOTE_100  = 6'b100000;

  localparam int VAL_5   = 5;
  localparam int VAL_10  = 10;
  localparam int VAL_20  = 20;
  localparam int VAL_50  = 50;
  localparam int VAL_100 = 100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SELECT,
    S_DISPENSE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ZERO    = 3'd1;
  localparam logic [2:0] ERR_MOD5    = 3'd2;
  localparam logic [2:0] ERR_OVER    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  // Remainder modulo 5 by MSB-first shift-and-reduce, avoiding a divider.
  function automatic logic [2:0] mod5(input logic [31:0] v);
    logic [3:0] t;
    logic [2:0] r;
    r = 3'd0;
    for (int i = 31; i >= 0; i--) begin
      t = {r, v[i]};
      if (t >= 4'd5) t = t - 4'd5;
      r = t[2:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/note_select.sv
// Greedy note picker: largest denomination not exceeding the remaining amount.
// Purely combinational so change-return logic can share it.
module note_select
  import atm_pkg::*;
#(
  parameter int AMT_W = 10
) (
  input  logic [AMT_W-1:0] i_remaining,
  output logic [5:0]       o_sel,
  output logic [AMT_W-1:0] o_value
);

  always_comb begin
    o_sel   = NOTE_NONE;
    o_value = '0;
    if (i_remaining >= AMT_W'(VAL_100)) begin
      o_sel   = NOTE_100;
      o_value = AMT_W'(VAL_100);
    end else if (i_remaining >= AMT_W'(VAL_50)) begin
      o_sel   = NOTE_50;
      o_value = AMT_W'(VAL_50);
    end else if (i_remaining >= AMT_W'(VAL_20)) begin
      o_sel   = NOTE_20;
      o_value = AMT_W'(VAL_20);
    end else if (i_remaining >= AMT_W'(VAL_10)) begin
      o_sel   = NOTE_10;
      o_value = AMT_W'(VAL_10);
    end else if (i_remaining >= AMT_W'(VAL_5)) begin
      o_sel   = NOTE_5;
      o_value = AMT_W'(VAL_5);
    end
  end

endmodule

// File: rtl/cash_dispenser.sv
// Turns a withdrawal amount into a greedy sequence of single-note dispense handshakes.
// Optional macro ACK_TIMEOUT_EN adds the TIMEOUT parameter and an ack-wait watchdog (error code 4).
module cash_dispenser
  import atm_pkg::*;
#(
  parameter int AMT_W      = 10,
  parameter int MAX_AMOUNT = 1000,
  parameter int CNT_W      = 8
`ifdef ACK_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 255
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             note_valid,
  output logic [5:0]       note_sel,
  input  logic             note_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] note_count
);

  localparam logic [AMT_W-1:0] MAX_A = AMT_W'(MAX_AMOUNT);

  state_t           r_state, w_nextState;
  logic [AMT_W-1:0] r_remaining, w_nextRemaining;
  logic [5:0]       r_noteSel, w_nextSel;
  logic [AMT_W-1:0] r_noteVal, w_nextVal;
  logic [CNT_W-1:0] r_noteCount, w_nextCount;
  logic [2:0]       r_errCode, w_nextErr;
  logic [5:0]       w_pickSel;
  logic [AMT_W-1:0] w_pickVal;
  logic [2:0]       w_mod5;

`ifdef ACK_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] r_toCnt, w_nextToCnt;
`endif

  note_select #(.AMT_W(AMT_W)) u_noteSelect (
    .i_remaining (r_remaining),
    .o_sel       (w_pickSel),
    .o_value     (w_pickVal)
  );

  assign w_mod5     = mod5(32'(r_remaining));
  assign note_count = r_noteCount;
  assign err_code   = r_errCode;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_noteSel   <= NOTE_NONE;
      r_noteVal   <= '0;
      r_noteCount <= '0;
      r_errCode   <= ERR_NONE;
`ifdef ACK_TIMEOUT_EN
      r_toCnt     <= '0;
`endif
    end else begin
      r_state     <= w_nextState;
      r_remaining <= w_nextRemaining;
      r_noteSel   <= w_nextSel;
      r_noteVal   <= w_nextVal;
      r_noteCount <= w_nextCount;
      r_errCode   <= w_nextErr;
`ifdef ACK_TIMEOUT_EN
      r_toCnt     <= w_nextToCnt;
`endif
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextRemaining = r_remaining;
    w_nextSel       = r_noteSel;
    w_nextVal       = r_noteVal;
    w_nextCount     = r_noteCount;
    w_nextErr       = r_errCode;
`ifdef ACK_TIMEOUT_EN
    w_nextToCnt     = r_toCnt;
`endif
    req_ready  = 1'b0;
    note_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          w_nextRemaining = req_amount;
          w_nextCount     = '0;
          w_nextErr       = ERR_NONE;
          w_nextState     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_remaining == '0) begin
          w_nextErr   = ERR_ZERO;
          w_nextState = S_ERROR;
        end else if (w_mod5 != 3'd0) begin
          w_nextErr   = ERR_MOD5;
          w_nextState = S_ERROR;
        end else if (r_remaining > MAX_A) begin
          w_nextErr   = ERR_OVER;
          w_nextState = S_ERROR;
        end else begin
          w_nextState = S_SELECT;
        end
      end
      S_SELECT: begin
        w_nextSel   = w_pickSel;
        w_nextVal   = w_pickVal;
`ifdef ACK_TIMEOUT_EN
        w_nextToCnt = '0;
`endif
        w_nextState = S_DISPENSE;
      end
      S_DISPENSE: begin
        note_valid = 1'b1;
        if (note_ack) begin
          // The picker guarantees r_noteVal <= r_remaining, so no underflow.
          w_nextRemaining = r_remaining - r_noteVal;
          if (r_noteCount != '1) w_nextCount = r_noteCount + 1'b1;
          w_nextState = (r_remaining == r_noteVal) ? S_DONE : S_SELECT;
        end
`ifdef ACK_TIMEOUT_EN
        else if (r_toCnt == TO_W'(TIMEOUT - 1)) begin
          w_nextErr       = ERR_TIMEOUT;
          w_nextRemaining = '0;
          w_nextState     = S_ERROR;
        end else begin
          w_nextToCnt = r_toCnt + 1'b1;
        end
`endif
      end
      S_DONE: begin
        done        = 1'b1;
        w_nextState = S_IDLE;
      end
      S_ERROR: begin
        err         = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase

    note_sel = note_valid ? r_noteSel : NOTE_NONE;
  end

endmodule

// File: tb/tb_cash_dispenser.sv
// Scoreboard bench for cash_dispenser: a greedy reference model queues expected events,
// a negedge monitor pops them on note handshakes, done and err pulses.
module tb_cash_dispenser;

  localparam int AMT_W      = 10;
  localparam int CNT_W      = 8;
  localparam int MAX_AMOUNT = 1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             note_ack = 1'b0;
  logic             req_ready, note_valid, busy, done, err;
  logic [5:0]       note_sel;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] note_count;

  cash_dispenser #(
    .AMT_W      (AMT_W),
    .MAX_AMOUNT (MAX_AMOUNT),
    .CNT_W      (CNT_W)
`ifdef ACK_TIMEOUT_EN
    ,
    .TIMEOUT    (8)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .note_valid (note_valid),
    .note_sel   (note_sel),
    .note_ack   (note_ack),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .note_count (note_count)
  );

  always #5 clk = ~clk;

  // kind: 0 = note taken (val = one-hot), 1 = done (cnt), 2 = err (val = code, cnt)
  typedef struct {
    int kind;
    int val;
    int cnt;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   notesSeen = 0;
  int   acceptCycle = 0;
  int   fixedDelay = -1;
  bit   withhold = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic void pushEvent(input int kind, input int val, input int cnt);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cnt  = cnt;
    expQ.push_back(e);
  endfunction

  // Reference model straight from the withdrawal rules; stall models a withheld second note.
  function automatic void pushExpected(input int amt, input bit stall);
    int vals[5] = '{100, 50, 20, 10, 5};
    int sels[5] = '{32, 16, 8, 4, 2};
    int rem = amt;
    int n = 0;
    if (amt == 0) pushEvent(2, 1, 0);
    else if (amt % 5 != 0) pushEvent(2, 2, 0);
    else if (amt > MAX_AMOUNT) pushEvent(2, 3, 0);
    else begin
      while (rem > 0) begin
        for (int k = 0; k < 5; k++) begin
          if (vals[k] <= rem) begin
            pushEvent(0, sels[k], 0);
            rem -= vals[k];
            n++;
            break;
          end
        end
        if (stall && n == 1 && rem > 0) begin
          pushEvent(2, 4, 1);
          return;
        end
      end
      pushEvent(1, 0, n);
    end
  endfunction

  task automatic popCheck(input int kind, input int val, input int cnt);
    exp_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_event: got kind %0d val %0d cnt %0d, expected none", kind, val, cnt);
    end else begin
      e = expQ.pop_front();
      checkOutput("event_kind", kind, e.kind);
      checkOutput("event_value", val, e.val);
      checkOutput("event_count", cnt, e.cnt);
    end
  endtask

  // Monitor: samples on the falling edge, well away from the active edge.
  bit       prevValid = 1'b0;
  bit       prevTaken = 1'b0;
  bit [5:0] prevSel = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("busy_vs_ready", int'(busy), int'(!req_ready));
      if (!note_valid) checkOutput("sel_zero_when_idle", int'(note_sel), 0);
      if (note_valid && prevValid && !prevTaken)
        checkOutput("sel_stable", int'(note_sel), int'(prevSel));
      if (note_valid && !prevValid && notesSeen == 0)
        checkOutput("first_note_latency", cycle - acceptCycle, 2);
      if (note_valid && note_ack) begin
        popCheck(0, int'(note_sel), 0);
        notesSeen++;
      end
      if (done) popCheck(1, 0, int'(note_count));
      if (err) popCheck(2, int'(err_code), int'(note_count));
    end
    prevValid = note_valid;
    prevSel   = note_sel;
    prevTaken = note_valid && note_ack;
  end

  // Note mechanism: random (or fixed) ack delay, spurious acks while no note is offered.
  initial begin
    int waited = 0;
    int target = 0;
    forever begin
      @(posedge clk);
      #1;
      if (note_valid) begin
        if (!(withhold && notesSeen >= 1) && waited >= target) begin
          note_ack = 1'b1;
          waited   = 0;
        end else begin
          note_ack = 1'b0;
          waited++;
        end
      end else begin
        note_ack = ($urandom_range(0, 5) == 0);
        waited   = 0;
        target   = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 3));
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_note_valid"}, int'(note_valid), 0);
    checkOutput({tag, "_note_sel"}, int'(note_sel), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_err"}, int'(err), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_req_ready"}, int'(req_ready), 1);
    checkOutput({tag, "_note_count"}, int'(note_count), 0);
    checkOutput({tag, "_err_code"}, int'(err_code), 0);
  endtask

  task automatic applyStimulus(input int amt, input bit stall, input bit useModel);
    int c = 0;
    while (!req_ready && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 200) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_wait: req_ready stayed %0d, required 1", req_ready);
    end
    if (useModel) pushExpected(amt, stall);
    req_valid  = 1'b1;
    req_amount = AMT_W'(amt);
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    req_amount  = AMT_W'($urandom);
    notesSeen   = 0;
    acceptCycle = cycle;
  endtask

  task automatic waitQuiet(input string tag);
    int c = 0;
    while (!(req_ready && expQ.size() == 0) && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 500) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_complete: %0d events outstanding, required 0", tag, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    int c;
    int amt;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;

    applyStimulus(185, 1'b0, 1'b1);  waitQuiet("amt185");
    applyStimulus(0, 1'b0, 1'b1);    waitQuiet("amt0");
    applyStimulus(7, 1'b0, 1'b1);    waitQuiet("amt7");
    applyStimulus(1005, 1'b0, 1'b1); waitQuiet("amt1005");
    applyStimulus(1000, 1'b0, 1'b1); waitQuiet("amt1000");
    fixedDelay = 4;
    applyStimulus(30, 1'b0, 1'b1);   waitQuiet("amt30_slow");
    fixedDelay = -1;

    // Reset during the second note of 150: only the first 100 note is ever taken.
    withhold = 1'b1;
    pushEvent(0, 32, 0);
    applyStimulus(150, 1'b0, 1'b0);
    c = 0;
    while (!(note_valid && notesSeen == 1) && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 100) begin
      total++;
      bad++;
      $display("[TB] FAIL second_note_wait: notes taken %0d, required 1", notesSeen);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkResetValues("midreset");
    rst_n    = 1'b1;
    withhold = 1'b0;
    checkOutput("queue_after_reset", expQ.size(), 0);
    expQ.delete();
    applyStimulus(5, 1'b0, 1'b1);    waitQuiet("amt5_after_reset");

`ifdef ACK_TIMEOUT_EN
    withhold = 1'b1;
    applyStimulus(55, 1'b1, 1'b1);   waitQuiet("amt55_timeout");
    withhold = 1'b0;
`endif

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) amt = int'($urandom_range(0, 1023));
      else amt = 5 * int'($urandom_range(0, 200));
      applyStimulus(amt, 1'b0, 1'b1);
      waitQuiet("random");
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
